// File: rtl/mem_port_arbiter_if.sv
// Bundle for the arbiter: fetch port, data port and the shared memory bus.
// The arbiter uses the slave view; the pipeline/memory environment uses master.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic              i_valid;
   logic [ADDR_W-1:0] i_addr;
   logic              i_flush;
   logic              i_ready;
   logic [DATA_W-1:0] i_rdata;

   logic              d_valid;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [STRB_W-1:0] d_wstrb;
   logic              d_ready;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [STRB_W-1:0] mem_wstrb;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  i_valid, i_addr, i_flush,
      output i_ready, i_rdata,
      input  d_valid, d_addr, d_wdata, d_wstrb,
      output d_ready, d_rdata,
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport master (
      output i_valid, i_addr, i_flush,
      input  i_ready, i_rdata,
      output d_valid, d_addr, d_wdata, d_wstrb,
      input  d_ready, d_rdata,
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between instruction fetch
// and the load/store port; data has fixed priority, flushed fetches are dropped.
//
// state  | meaning
// IDLE   | no bus cycle; arbitrate (data first, then unflushed fetch)
// BUSY_I | fetch on the bus; wait for mem_ready
// BUSY_D | load/store on the bus; wait for mem_ready
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus
);
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_drop;
   logic              w_drop_nxt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [ADDR_W-1:0] w_mem_addr_nxt;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] w_mem_wdata_nxt;
   logic [STRB_W-1:0] r_mem_wstrb;
   logic [STRB_W-1:0] w_mem_wstrb_nxt;

   logic              w_i_ready;
   logic [DATA_W-1:0] w_i_rdata;
   logic              w_d_ready;
   logic [DATA_W-1:0] w_d_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_drop      <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wstrb <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_drop      <= w_drop_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_mem_wstrb <= w_mem_wstrb_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_drop_nxt      = r_drop;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_mem_wstrb_nxt = r_mem_wstrb;
      w_i_ready       = 1'b0;
      w_i_rdata       = '0;
      w_d_ready       = 1'b0;
      w_d_rdata       = '0;

      case (r_state)
         IDLE: begin
            // mem_ready is deliberately ignored here (e.g. a late ack after reset)
            if (bus.d_valid) begin
               w_state_nxt     = BUSY_D;
               w_mem_addr_nxt  = bus.d_addr;
               w_mem_wdata_nxt = bus.d_wdata;
               w_mem_wstrb_nxt = bus.d_wstrb;
            end else if (bus.i_valid && !bus.i_flush) begin
               w_state_nxt     = BUSY_I;
               w_mem_addr_nxt  = bus.i_addr;
               w_mem_wdata_nxt = '0;
               w_mem_wstrb_nxt = '0;
               w_drop_nxt      = 1'b0;
            end
         end

         BUSY_I: begin
            // A redirect cannot abort the bus cycle; remember to discard its data.
            if (bus.i_flush) begin
               w_drop_nxt = 1'b1;
            end
            if (bus.mem_ready) begin
               w_state_nxt = IDLE;
               if (!(r_drop || bus.i_flush)) begin
                  w_i_ready = 1'b1;
                  w_i_rdata = bus.mem_rdata;
               end
            end
         end

         BUSY_D: begin
            if (bus.mem_ready) begin
               w_state_nxt = IDLE;
               w_d_ready   = 1'b1;
               w_d_rdata   = bus.mem_rdata;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign bus.mem_valid = (r_state != IDLE);
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_wstrb = r_mem_wstrb;
   assign bus.i_ready   = w_i_ready;
   assign bus.i_rdata   = w_i_rdata;
   assign bus.d_ready   = w_d_ready;
   assign bus.d_rdata   = w_d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: priority, flush/drop handling,
// address hold during long waits and synchronous reset mid-transaction.
module tb_mem_port_arbiter;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.i_valid = 0; bus.i_addr = '0; bus.i_flush = 0;
      bus.d_valid = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
      bus.mem_ready = 0; bus.mem_rdata = '0;
      nxt(); nxt();
      #1;
      chk("reset_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
      chk("reset_mem_addr", bus.mem_addr, 32'd0);

      // Plain fetch with 1-cycle memory
      nxt(); rst = 1'b0; bus.i_valid = 1; bus.i_addr = 32'h100; #1;
      chk("f1_c0_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
      nxt(); #1;
      chk("f1_c1_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
      chk("f1_c1_mem_addr", bus.mem_addr, 32'h100);
      chk("f1_c1_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
      chk("f1_c1_i_ready", {31'd0, bus.i_ready}, 32'd0);
      nxt(); bus.mem_ready = 1; bus.mem_rdata = 32'h13; #1;
      chk("f1_c2_i_ready", {31'd0, bus.i_ready}, 32'd1);
      chk("f1_c2_i_rdata", bus.i_rdata, 32'h13);
      chk("f1_c2_d_ready", {31'd0, bus.d_ready}, 32'd0);
      nxt(); bus.i_valid = 0; bus.mem_ready = 0; #1;
      chk("f1_c3_mem_valid", {31'd0, bus.mem_valid}, 32'd0);

      // Simultaneous requests: data first, bubble, then fetch
      nxt();
      bus.i_valid = 1; bus.i_addr = 32'h104;
      bus.d_valid = 1; bus.d_addr = 32'h2004; bus.d_wstrb = 4'b0011; bus.d_wdata = 32'hBEEF;
      nxt(); #1;
      chk("pr_c1_mem_addr", bus.mem_addr, 32'h2004);
      chk("pr_c1_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'h3);
      chk("pr_c1_mem_wdata", bus.mem_wdata, 32'hBEEF);
      nxt(); bus.mem_ready = 1; bus.mem_rdata = 32'h0; #1;
      chk("pr_c2_d_ready", {31'd0, bus.d_ready}, 32'd1);
      chk("pr_c2_i_ready", {31'd0, bus.i_ready}, 32'd0);
      nxt(); bus.d_valid = 0; bus.mem_ready = 0; #1;
      chk("pr_c3_bubble", {31'd0, bus.mem_valid}, 32'd0);
      nxt(); bus.mem_ready = 1; bus.mem_rdata = 32'h55; #1;
      chk("pr_c4_mem_addr", bus.mem_addr, 32'h104);
      chk("pr_c4_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
      chk("pr_c4_mem_wdata", bus.mem_wdata, 32'd0);
      chk("pr_c4_i_ready", {31'd0, bus.i_ready}, 32'd1);
      chk("pr_c4_i_rdata", bus.i_rdata, 32'h55);
      nxt(); bus.i_valid = 0; bus.mem_ready = 0;

      // Flush in 2nd busy cycle of a 3-cycle fetch
      nxt(); bus.i_valid = 1; bus.i_addr = 32'h108;
      nxt();
      nxt(); bus.i_flush = 1; bus.i_valid = 0; #1;
      chk("fl_c2_i_ready", {31'd0, bus.i_ready}, 32'd0);
      nxt(); bus.i_flush = 0; bus.i_valid = 1; bus.i_addr = 32'h200; #1;
      chk("fl_c3_mem_addr", bus.mem_addr, 32'h108);
      nxt(); bus.mem_ready = 1; bus.mem_rdata = 32'h77; #1;
      chk("fl_c4_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
      chk("fl_c4_i_ready", {31'd0, bus.i_ready}, 32'd0);
      chk("fl_c4_i_rdata", bus.i_rdata, 32'd0);
      nxt(); bus.mem_ready = 0; #1;
      chk("fl_c5_bubble", {31'd0, bus.mem_valid}, 32'd0);
      nxt(); bus.mem_ready = 1; bus.mem_rdata = 32'h99; #1;
      chk("fl_c6_mem_addr", bus.mem_addr, 32'h200);
      chk("fl_c6_i_ready", {31'd0, bus.i_ready}, 32'd1);
      chk("fl_c6_i_rdata", bus.i_rdata, 32'h99);
      nxt(); bus.i_valid = 0; bus.mem_ready = 0;

      // Flush coincident with mem_ready
      nxt(); bus.i_valid = 1; bus.i_addr = 32'h300;
      nxt();
      nxt(); bus.mem_ready = 1; bus.mem_rdata = 32'h66; bus.i_flush = 1; bus.i_valid = 0; #1;
      chk("fc_i_ready", {31'd0, bus.i_ready}, 32'd0);
      chk("fc_i_rdata", bus.i_rdata, 32'd0);
      nxt(); bus.mem_ready = 0; bus.i_flush = 0; #1;
      chk("fc_idle", {31'd0, bus.mem_valid}, 32'd0);

      // Load with 5-cycle latency, d_addr toggled meanwhile
      nxt(); bus.d_valid = 1; bus.d_addr = 32'h3000; bus.d_wstrb = 4'b0000; bus.d_wdata = 32'h0;
      bus.mem_rdata = 32'hAABBCCDD;
      nxt(); #1;
      chk("ld_c1_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
      nxt(); bus.d_addr = 32'h3FFC; #1;
      chk("ld_c2_mem_addr", bus.mem_addr, 32'h3000);
      chk("ld_c2_d_rdata", bus.d_rdata, 32'd0);
      nxt(); bus.d_addr = 32'h3000;
      nxt(); bus.d_addr = 32'h3FFC;
      nxt(); #1;
      chk("ld_c5_d_ready", {31'd0, bus.d_ready}, 32'd0);
      nxt(); bus.mem_ready = 1; #1;
      chk("ld_c6_mem_addr", bus.mem_addr, 32'h3000);
      chk("ld_c6_d_ready", {31'd0, bus.d_ready}, 32'd1);
      chk("ld_c6_d_rdata", bus.d_rdata, 32'hAABBCCDD);
      nxt(); bus.d_valid = 0; bus.mem_ready = 0;

      // Reset mid BUSY_D, late mem_ready ignored
      nxt(); bus.d_valid = 1; bus.d_addr = 32'h4000; bus.d_wstrb = 4'hF; bus.d_wdata = 32'h1234;
      nxt(); #1;
      chk("rs_c1_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
      nxt(); rst = 1;
      nxt(); rst = 0; bus.d_valid = 0; bus.mem_ready = 1; bus.mem_rdata = 32'hDEAD; #1;
      chk("rs_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
      chk("rs_mem_addr", bus.mem_addr, 32'd0);
      chk("rs_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rs_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
      chk("rs_d_ready", {31'd0, bus.d_ready}, 32'd0);
      chk("rs_d_rdata", bus.d_rdata, 32'd0);
      chk("rs_i_ready", {31'd0, bus.i_ready}, 32'd0);
      nxt(); bus.mem_ready = 0; #1;
      chk("rs_still_idle", {31'd0, bus.mem_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage load/store, feeding the writeback load-alignment path).
- One bus transaction is in flight at a time; the grant is registered and the request is latched at grant.
- Data requests have fixed priority over fetches; the pipeline stalls on the requester's missing ready.
- A fetch flush discards the response of an in-flight fetch without aborting the bus cycle.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; must be 32 (one 4-bit byte strobe).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- i_valid  in  1  fetch request; held with stable i_addr until i_ready or i_flush
- i_addr  in  ADDR_W  fetch address (word aligned)
- i_flush  in  1  cancel fetch (branch/jump redirect)
- i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  out  32  fetch data
- d_valid  in  1  data request; held with stable addr/wdata/wstrb until d_ready
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data (pre-shifted to lane)
- d_wstrb  in  4  byte strobes; 4'b0000 = load
- d_ready  out  1  one-cycle pulse: data access complete, d_rdata valid (raw word, aligned later)
- d_rdata  out  32  load data
- mem_valid  out  1  bus request
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  32  latched write data
- mem_wstrb  out  4  latched strobes (0 for fetch)
- mem_ready  in  1  bus completion, any latency ≥1 cycle after mem_valid
- mem_rdata  in  32  bus read data, valid with mem_ready

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D; state is registered.
- mem_valid = (state != IDLE).
- IDLE transitions:
  - d_valid → BUSY_D; latch d_addr/d_wdata/d_wstrb into mem_*.
  - else i_valid & !i_flush → BUSY_I; latch i_addr, mem_wdata = 0, mem_wstrb = 0; clear drop flag.
  - Both valid in the same cycle: data wins; the fetch waits.
- Latency: request seen in IDLE at cycle N → mem_valid = 1 at N+1 → requester ready in the mem_ready cycle.
- Minimum round trip is 2 cycles with a 1-cycle memory.
- BUSY_D: on mem_ready, d_ready = 1 and d_rdata = mem_rdata (combinational pass-through); next state IDLE.
- BUSY_I: on mem_ready, i_ready = !(drop | i_flush) and i_rdata = mem_rdata; next state IDLE.
- Drop flag:
  - Set by i_flush in any cycle of BUSY_I.
  - i_flush in the same cycle as mem_ready also suppresses i_ready.
  - Cleared on entry to BUSY_I.
- i_flush in IDLE or BUSY_D has no stored effect; it only blocks an IDLE fetch grant that same cycle.
- After each completion the FSM passes through IDLE for one bubble cycle. A requester still holding valid in that IDLE cycle is re-arbitrated normally.
- mem_addr/mem_wdata/mem_wstrb are held stable for the whole BUSY state, regardless of input changes.
- i_rdata/d_rdata are 0 whenever the matching ready is 0.
- Reset (synchronous, any state, including mid-transaction):
  - state = IDLE, drop = 0.
  - mem_valid, i_ready, d_ready = 0; mem_addr, mem_wdata, mem_wstrb = 0.
  - A mem_ready arriving after reset is ignored in IDLE.
- mem_ready is ignored in IDLE.
- Data priority cannot starve fetch, because the MEM stage issues at most one access per instruction.

Test Plan:
- Reset, then i_valid with i_addr = 0x100 and 1-cycle memory returning 0x00000013 → mem_valid at cycle 1, mem_wstrb = 0, i_ready pulse at cycle 2 with i_rdata = 0x00000013; d_ready stays 0.
- i_valid and d_valid both asserted at cycle 0 (d_addr = 0x2004, d_wstrb = 4'b0011, d_wdata = 0xBEEF) → BUSY_D first with mem_addr = 0x2004 and mem_wstrb = 0x3; d_ready on completion; one IDLE bubble; then fetch granted with mem_wstrb = 0.
- Fetch in flight with 3-cycle memory latency, i_flush pulsed in the 2nd BUSY cycle → transaction completes on the bus, i_ready never pulses; next i_valid (addr 0x200) is granted after IDLE.
- i_flush coincident with mem_ready in BUSY_I → i_ready = 0; the FSM still returns to IDLE.
- Load from 0x3000 with d_wstrb = 0 and memory returning 0xAABBCCDD after 5 cycles, d_addr toggled during the wait → mem_addr stays 0x3000; d_rdata = 0xAABBCCDD with d_ready.
- rst asserted mid BUSY_D, then mem_ready raised afterwards → all outputs 0 the cycle after rst, no d_ready pulse, FSM in IDLE.
